// File: rtl/seq_det_311.sv
// Moore detector for the serial pattern 1011 with a saturating detection counter.
// Define SEQ_DET_OVERLAP_EN to let the tail of a match start the next match.
module seq_det_311 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_311,
    input  logic             din_311,
    input  logic             en_311,
    output logic             det_311,
    output logic [CNT_W-1:0] count_311,
    output logic [2:0]       state_311
);

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_r;
    logic [2:0]       next_state_s;
    logic             det_r;
    logic [CNT_W-1:0] count_r;
    logic             hit_s;
    logic             sat_s;

    // Next-state decode; illegal codes fall back to idle.
    always_comb begin
        next_state_s = S0;
        case (state_r)
            S0: begin
                if (din_311) next_state_s = S1;
                else         next_state_s = S0;
            end
            S1: begin
                if (din_311) next_state_s = S1;
                else         next_state_s = S2;
            end
            S2: begin
                if (din_311) next_state_s = S3;
                else         next_state_s = S0;
            end
            S3: begin
                if (din_311) next_state_s = S4;
                else         next_state_s = S2;
            end
            S4: begin
`ifdef SEQ_DET_OVERLAP_EN
                if (din_311) next_state_s = S1;
                else         next_state_s = S2;
`else
                if (din_311) next_state_s = S1;
                else         next_state_s = S0;
`endif
            end
            default: next_state_s = S0;
        endcase
    end

    assign hit_s = (next_state_s == S4);
    assign sat_s = (count_r == CNT_MAX);

    // det is registered alongside the state so it tracks state==S4 with no path from din.
    always_ff @(posedge clk or posedge reset_311) begin
        if (reset_311) begin
            state_r <= S0;
            det_r   <= 1'b0;
            count_r <= '0;
        end else if (en_311) begin
            state_r <= next_state_s;
            det_r   <= hit_s;
            if (hit_s && !sat_s) begin
                count_r <= count_r + CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end else begin
            state_r <= state_r;
            det_r   <= det_r;
            count_r <= count_r;
        end
    end

    assign det_311   = det_r;
    assign count_311 = count_r;
    assign state_311 = state_r;

endmodule
